// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: MEM-stage core port vs. bursting external loader; one beat per cycle, core preferred.
// Optional DMEM_ARB_STARVE_LIMIT_EN: bounds core stall time during long external bursts.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int WORD_WIDTH   = 16,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [WORD_WIDTH-1:0] core_wdata,
  output logic                  core_stall,
  output logic [WORD_WIDTH-1:0] core_rdata,
  output logic                  core_rvalid,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [WORD_WIDTH-1:0] ext_wdata,
  input  logic                  ext_last,
  output logic                  ext_gnt,
  output logic [WORD_WIDTH-1:0] ext_rdata,
  output logic                  ext_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [WORD_WIDTH-1:0] mem_wr_word,
  output logic                  mem_write_en,
  input  logic [WORD_WIDTH-1:0] mem_rd_word
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {IDLE, CORE, EXT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             turn_q;
  logic             rd_core_q, rd_ext_q;
  logic             core_acc, ext_acc, burst_end, starve_hit;

  assign burst_end = ext_acc && (ext_last || burst_cnt == CNT_W'(MAX_BURST - 1));

`ifdef DMEM_ARB_STARVE_LIMIT_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  assign starve_hit = (state == EXT) && core_stall && (starve_cnt == SW'(STARVE_LIMIT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (starve_hit || !(state == EXT && core_stall))
      starve_cnt <= '0;
    else
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      turn_q    <= 1'b0;
      rd_core_q <= 1'b0;
      rd_ext_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      turn_q    <= burst_end && (state_nxt == EXT);
      rd_core_q <= core_acc && !core_we;
      rd_ext_q  <= ext_acc && !ext_we;
    end
  end

  // A burst that ends with the loader still requesting re-enters EXT through one
  // idle turnaround cycle (turn_q) so each grant is at most MAX_BURST back-to-back beats.
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (core_req)     state_nxt = CORE;
        else if (ext_req) state_nxt = EXT;
      end
      CORE: begin
        if (!core_req) state_nxt = ext_req ? EXT : IDLE;
      end
      EXT: begin
        if (!ext_req)                     state_nxt = IDLE;
        else if (starve_hit)              state_nxt = CORE;
        else if (burst_end)               state_nxt = core_req ? CORE : EXT;
        else if (turn_q && core_req)      state_nxt = CORE;
      end
      default: state_nxt = IDLE;
    endcase
    if (burst_end || starve_hit || state_nxt != EXT)
      burst_cnt_nxt = '0;
    else if (ext_acc)
      burst_cnt_nxt = burst_cnt + 1'b1;
  end

  // Outputs are gated by reset so every port reads zero during the reset cycle.
  always_comb begin
    core_acc = 1'b0;
    ext_acc  = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          core_acc = core_req;
          ext_acc  = !core_req && ext_req;
        end
        CORE:    core_acc = core_req;
        EXT:     ext_acc  = ext_req && !turn_q;
        default: ;
      endcase
    end
    mem_rd_addr  = '0;
    mem_wr_addr  = '0;
    mem_wr_word  = '0;
    mem_write_en = 1'b0;
    if (core_acc) begin
      mem_rd_addr  = core_addr;
      mem_wr_addr  = core_addr;
      mem_wr_word  = core_wdata;
      mem_write_en = core_we;
    end else if (ext_acc) begin
      mem_rd_addr  = ext_addr;
      mem_wr_addr  = ext_addr;
      mem_wr_word  = ext_wdata;
      mem_write_en = ext_we;
    end
    core_stall  = core_req && !core_acc && !reset;
    ext_gnt     = ext_acc;
    core_rvalid = rd_core_q;
    ext_rvalid  = rd_ext_q;
    core_rdata  = rd_core_q ? mem_rd_word : '0;
    ext_rdata   = rd_ext_q ? mem_rd_word : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural DMEM (one-cycle read latency).
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        core_req, core_we, core_stall, core_rvalid;
  logic [11:0] core_addr;
  logic [15:0] core_wdata, core_rdata;
  logic        ext_req, ext_we, ext_last, ext_gnt, ext_rvalid;
  logic [11:0] ext_addr;
  logic [15:0] ext_wdata, ext_rdata;
  logic [11:0] mem_rd_addr, mem_wr_addr;
  logic [15:0] mem_wr_word, mem_rd_word;
  logic        mem_write_en;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_last(ext_last), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_word(mem_wr_word),
    .mem_write_en(mem_write_en), .mem_rd_word(mem_rd_word)
  );

  // DMEM model: unwritten words hold a fixed pattern, a few addresses hold known constants.
  logic [15:0] mem [0:4095];
  bit          wr_seen [0:4095];

  function automatic logic [15:0] init_word(input logic [11:0] a);
    case (a)
      12'h010: return 16'hBEEF;
      12'h030: return 16'h5A5A;
      default: return {4'h3, a};
    endcase
  endfunction

  always @(posedge clock) begin
    if (mem_write_en) begin
      mem[mem_wr_addr]     <= mem_wr_word;
      wr_seen[mem_wr_addr] <= 1'b1;
    end
    mem_rd_word <= wr_seen[mem_rd_addr] ? mem[mem_rd_addr] : init_word(mem_rd_addr);
  end

  task automatic idle_inputs;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0; ext_last = 0;
  endtask

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1;
    idle_inputs();
    core_req = 1; core_we = 1; core_addr = 12'h055; core_wdata = 16'h1111;
    ext_req = 1; ext_we = 1; ext_addr = 12'h066; ext_wdata = 16'h2222;
    @(negedge clock);
    total++; if (ext_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=0", ext_gnt); end
    total++; if (mem_write_en !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", mem_write_en); end
    total++; if (mem_wr_addr !== 12'h000 || mem_rd_addr !== 12'h000 || mem_wr_word !== 16'h0)
      begin bad++; $display("FAIL reset_mem got=%h/%h/%h exp=0", mem_wr_addr, mem_rd_addr, mem_wr_word); end
    total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", core_stall); end
    total++; if (core_rvalid !== 1'b0 || ext_rvalid !== 1'b0 || core_rdata !== 16'h0 || ext_rdata !== 16'h0)
      begin bad++; $display("FAIL reset_rd got=%b%b %h %h exp=0", core_rvalid, ext_rvalid, core_rdata, ext_rdata); end
    next_cycle();
    reset = 0;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_core_read;
    core_req = 1; core_we = 0; core_addr = 12'h010;
    @(negedge clock);
    total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL core_rd_stall got=%b exp=0", core_stall); end
    total++; if (mem_rd_addr !== 12'h010 || mem_write_en !== 1'b0)
      begin bad++; $display("FAIL core_rd_addr got=%h we=%b exp=010 we=0", mem_rd_addr, mem_write_en); end
    next_cycle();
    core_req = 0;
    @(negedge clock);
    total++; if (core_rvalid !== 1'b1 || core_rdata !== 16'hBEEF)
      begin bad++; $display("FAIL core_rd_data got=%b %h exp=1 beef", core_rvalid, core_rdata); end
    total++; if (ext_rvalid !== 1'b0 || ext_rdata !== 16'h0)
      begin bad++; $display("FAIL core_rd_ext_quiet got=%b %h exp=0 0", ext_rvalid, ext_rdata); end
    next_cycle();
    @(negedge clock);
    total++; if (core_rvalid !== 1'b0 || core_rdata !== 16'h0)
      begin bad++; $display("FAIL core_rd_pulse got=%b %h exp=0 0", core_rvalid, core_rdata); end
    next_cycle();
  endtask

  task automatic test_priority;
    core_req = 1; core_we = 1; core_addr = 12'h020; core_wdata = 16'h1234;
    ext_req = 1; ext_we = 0; ext_addr = 12'h030; ext_last = 1;
    @(negedge clock);
    total++; if (ext_gnt !== 1'b0 || core_stall !== 1'b0)
      begin bad++; $display("FAIL prio_core_wins got=gnt%b stall%b exp=0 0", ext_gnt, core_stall); end
    total++; if (mem_write_en !== 1'b1 || mem_wr_addr !== 12'h020 || mem_wr_word !== 16'h1234)
      begin bad++; $display("FAIL prio_core_wr got=%b %h %h exp=1 020 1234", mem_write_en, mem_wr_addr, mem_wr_word); end
    next_cycle();
    core_req = 0;
    @(negedge clock);
    total++; if (ext_gnt !== 1'b0 || mem_write_en !== 1'b0)
      begin bad++; $display("FAIL prio_handover got=gnt%b we%b exp=0 0", ext_gnt, mem_write_en); end
    total++; if (core_rvalid !== 1'b0) begin bad++; $display("FAIL prio_wr_no_rvalid got=%b exp=0", core_rvalid); end
    next_cycle();
    @(negedge clock);
    total++; if (ext_gnt !== 1'b1 || mem_rd_addr !== 12'h030)
      begin bad++; $display("FAIL prio_ext_gnt got=%b %h exp=1 030", ext_gnt, mem_rd_addr); end
    next_cycle();
    idle_inputs();
    @(negedge clock);
    total++; if (ext_rvalid !== 1'b1 || ext_rdata !== 16'h5A5A || core_rvalid !== 1'b0)
      begin bad++; $display("FAIL prio_ext_rd got=%b %h core%b exp=1 5a5a 0", ext_rvalid, ext_rdata, core_rvalid); end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_ext_write_burst;
    for (int i = 0; i < 3; i++) begin
      ext_req = 1; ext_we = 1; ext_addr = 12'h100 + 12'(i); ext_wdata = 16'hA000 + 16'(i); ext_last = (i == 2);
      @(negedge clock);
      total++; if (ext_gnt !== 1'b1 || mem_write_en !== 1'b1 || mem_wr_addr !== 12'h100 + 12'(i) || mem_wr_word !== 16'hA000 + 16'(i))
        begin bad++; $display("FAIL wr_burst_beat%0d got=%b %b %h %h", i, ext_gnt, mem_write_en, mem_wr_addr, mem_wr_word); end
      next_cycle();
    end
    idle_inputs();
    @(negedge clock);
    total++; if (mem_write_en !== 1'b0 || ext_gnt !== 1'b0 || ext_rvalid !== 1'b0)
      begin bad++; $display("FAIL wr_burst_end got=we%b gnt%b rv%b exp=0 0 0", mem_write_en, ext_gnt, ext_rvalid); end
    next_cycle();
    core_req = 1; core_addr = 12'h101;
    @(negedge clock);
    total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL wr_burst_idle got=%b exp=0", core_stall); end
    next_cycle();
    core_req = 0;
    @(negedge clock);
    total++; if (core_rvalid !== 1'b1 || core_rdata !== 16'hA001)
      begin bad++; $display("FAIL wr_burst_readback got=%b %h exp=1 a001", core_rvalid, core_rdata); end
    next_cycle();
  endtask

  task automatic test_long_burst;
    logic [12:0] exp_gnt;
    int n;
    exp_gnt = 13'h1EFF;
    n = 0;
    for (int c = 0; c < 13; c++) begin
      ext_req = 1; ext_we = 0; ext_addr = 12'h200 + 12'(n); ext_last = 0;
      @(negedge clock);
      total++; if (ext_gnt !== exp_gnt[c])
        begin bad++; $display("FAIL long_gnt_c%0d got=%b exp=%b", c, ext_gnt, exp_gnt[c]); end
      if (c > 0) begin
        total++; if (ext_rvalid !== exp_gnt[c-1])
          begin bad++; $display("FAIL long_rvalid_c%0d got=%b exp=%b", c, ext_rvalid, exp_gnt[c-1]); end
        if (exp_gnt[c-1] && n > 0) begin
          total++; if (ext_rdata !== 16'h3200 + 16'(n - 1))
            begin bad++; $display("FAIL long_rdata_c%0d got=%h exp=%h", c, ext_rdata, 16'h3200 + 16'(n - 1)); end
        end
      end
      if (ext_gnt === 1'b1) n++;
      next_cycle();
    end
    idle_inputs();
    @(negedge clock);
    total++; if (n != 12 || ext_rvalid !== 1'b1)
      begin bad++; $display("FAIL long_total got=%0d rv%b exp=12 1", n, ext_rvalid); end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_starve;
    int k;
    int n;
`ifdef DMEM_ARB_STARVE_LIMIT_EN
    k = 5;
`else
    k = 8;
`endif
    n = 0;
    for (int c = 0; c <= k; c++) begin
      ext_req = (n < 8); ext_we = 0; ext_addr = 12'h400 + 12'(n); ext_last = (n == 7);
      core_req = (c >= 1); core_we = 0; core_addr = 12'h010;
      @(negedge clock);
      total++; if (core_stall !== ((c >= 1) && (c < k)))
        begin bad++; $display("FAIL starve_stall_c%0d got=%b exp=%b", c, core_stall, (c >= 1) && (c < k)); end
      total++; if (ext_gnt !== (c < k))
        begin bad++; $display("FAIL starve_gnt_c%0d got=%b exp=%b", c, ext_gnt, c < k); end
      if (ext_gnt === 1'b1) n++;
      next_cycle();
    end
    core_req = 0;
    for (int c = 0; c < 20 && n < 8; c++) begin
      ext_req = 1; ext_addr = 12'h400 + 12'(n); ext_last = (n == 7);
      @(negedge clock);
      if (ext_gnt === 1'b1) n++;
      next_cycle();
    end
    idle_inputs();
    total++; if (n != 8) begin bad++; $display("FAIL starve_resume got=%0d beats exp=8", n); end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_mid_burst;
    for (int i = 0; i < 2; i++) begin
      ext_req = 1; ext_we = 0; ext_addr = 12'h500 + 12'(i); ext_last = 0;
      @(negedge clock);
      total++; if (ext_gnt !== 1'b1) begin bad++; $display("FAIL rst_burst_beat%0d got=%b exp=1", i, ext_gnt); end
      next_cycle();
    end
    ext_addr = 12'h502;
    reset = 1;
    @(negedge clock);
    total++; if (ext_gnt !== 1'b0 || mem_write_en !== 1'b0 || mem_rd_addr !== 12'h000 || core_stall !== 1'b0)
      begin bad++; $display("FAIL rst_burst_outs got=%b %b %h %b exp=0", ext_gnt, mem_write_en, mem_rd_addr, core_stall); end
    total++; if (ext_rvalid !== 1'b0 || ext_rdata !== 16'h0)
      begin bad++; $display("FAIL rst_burst_rvalid got=%b %h exp=0 0", ext_rvalid, ext_rdata); end
    next_cycle();
    reset = 0;
    idle_inputs();
    @(negedge clock);
    total++; if (ext_rvalid !== 1'b0) begin bad++; $display("FAIL rst_burst_next_rv got=%b exp=0", ext_rvalid); end
    next_cycle();
    core_req = 1; ext_req = 1; ext_addr = 12'h503;
    @(negedge clock);
    total++; if (core_stall !== 1'b0 || ext_gnt !== 1'b0)
      begin bad++; $display("FAIL rst_burst_idle got=stall%b gnt%b exp=0 0", core_stall, ext_gnt); end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_priority();
    test_ext_write_burst();
    test_long_burst();
    test_starve();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
